// File: rtl/nanov_alu_seq.sv
// Bit-serial operand driver / result collector for the nanoV serial ALU.
// Optional feature macro NANOV_ALU_SEQ_CHAIN_EN: accept a new start in the DONE cycle.
module nanov_alu_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a_in,
    input  logic [XLEN-1:0] b_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [3:0]      alu_op,
    output logic            alu_a,
    output logic            alu_b,
    output logic            alu_cy_in,
    input  logic            alu_d,
    input  logic            alu_cy_out,
    input  logic            alu_lts
);
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic            accept;
    logic            running;
    logic            last;
    logic [XLEN-1:0] a_sh, b_sh, r_sh;
    logic [XLEN-1:0] r_full, r_final;
    logic            carry;
    logic [CNT_W-1:0] cnt;

    assign running = (state == S_RUN);
    assign last    = running && (cnt == CNT_LAST);

`ifdef NANOV_ALU_SEQ_CHAIN_EN
    assign accept = start && ((state == S_IDLE) || (state == S_DONE));
`else
    assign accept = start && (state == S_IDLE);
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_RUN;
            S_RUN:   if (last)   state_nxt = S_DONE;
            S_DONE:  state_nxt = accept ? S_RUN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Final bit comes straight from the ALU; earlier bits are already in r_sh.
    assign r_full = {alu_d, r_sh[XLEN-1:1]};

    always_comb begin
        r_final = r_full;
        case (alu_op)
            OP_SLT:  r_final = {{(XLEN-1){1'b0}}, alu_lts};
            OP_SLTU: r_final = {{(XLEN-1){1'b0}}, ~alu_cy_out};
            default: r_final = r_full;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            alu_op <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            r_sh   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            result <= '0;
        end else if (accept) begin
            alu_op <= op;
            a_sh   <= a_in;
            b_sh   <= b_in;
            carry  <= op[1] | op[3];
            cnt    <= '0;
        end else if (running) begin
            a_sh  <= {1'b0, a_sh[XLEN-1:1]};
            b_sh  <= {1'b0, b_sh[XLEN-1:1]};
            r_sh  <= r_full;
            carry <= alu_cy_out;
            cnt   <= cnt + CNT_W'(1);
            if (last) result <= r_final;
        end
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign alu_a     = running & a_sh[0];
    assign alu_b     = running & b_sh[0];
    assign alu_cy_in = running & carry;

endmodule

// File: tb/tb_nanov_alu_seq.sv
// Randomized self-checking bench for nanov_alu_seq with a combinational serial ALU model.
module tb_nanov_alu_seq;
    logic        clk, rstn, start;
    logic [3:0]  op;
    logic [31:0] a_in, b_in, result;
    logic        busy, done, alu_a, alu_b, alu_cy_in;
    logic [3:0]  alu_op;
    logic        alu_d, alu_cy_out, alu_lts;
    logic        sub, bx;

    int n_chk  = 0;
    int n_pass = 0;

    nanov_alu_seq #(.XLEN(32)) dut (
        .clk(clk), .rstn(rstn), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
        .busy(busy), .done(done), .result(result), .alu_op(alu_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cy_in(alu_cy_in),
        .alu_d(alu_d), .alu_cy_out(alu_cy_out), .alu_lts(alu_lts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serial ALU: one-bit full adder (B inverted for subtract-type ops) or bitwise logic.
    always_comb begin
        sub = alu_op[3] | alu_op[1];
        bx  = alu_b ^ sub;
        case (alu_op)
            4'b0111: alu_d = alu_a & alu_b;
            4'b0110: alu_d = alu_a | alu_b;
            4'b0100: alu_d = alu_a ^ alu_b;
            default: alu_d = alu_a ^ bx ^ alu_cy_in;
        endcase
        alu_cy_out = (alu_a & bx) | (alu_a & alu_cy_in) | (bx & alu_cy_in);
        alu_lts    = (alu_a ^ alu_b) ? alu_a : (alu_a ^ bx ^ alu_cy_in);
    end

    function automatic logic [31:0] ref_alu(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        case (o)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: return (a < b) ? 32'd1 : 32'd0;
            4'b0111: return a & b;
            4'b0110: return a | b;
            4'b0100: return a ^ b;
            default: return a + b;  // undefined op: plain serial add result passed through
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Issue one op; optionally pulse start again at cycles inj1/inj2 after acceptance.
    task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int inj1, input int inj2);
        int          done_cyc, n_done, n_busy;
        logic [31:0] res, exp;
        logic        idle_bits;
        exp = ref_alu(o, a, b);
        done_cyc = 0; n_done = 0; n_busy = 0; res = '0; idle_bits = 1'b1;
        @(negedge clk);
        start = 1'b1; op = o; a_in = a; b_in = b;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == inj1 || c == inj2) begin
                start = 1'b1; a_in = 32'h100; b_in = 32'h200;
            end else start = 1'b0;
            if (busy) n_busy++;
            if (c == 1) chk("alu_op", 32'(alu_op), 32'(o));
            if (done) begin
                n_done++;
                if (done_cyc == 0) begin
                    done_cyc  = c;
                    res       = result;
                    idle_bits = alu_a | alu_b | alu_cy_in;
                end
            end
        end
        start = 1'b0;
        chk("done_latency", 32'(done_cyc), 32'd33);
        chk("done_count", 32'(n_done), 32'd1);
        chk("busy_cycles", 32'(n_busy), 32'd33);
        chk("result", res, exp);
        chk("result_hold", result, exp);
        chk("alu_idle_bits", 32'(idle_bits), 32'd0);
    endtask

    logic [3:0] ops [7];
    int quiet, d1, d2, drop;
    logic [31:0] ra, rb;

    initial begin
        ops = '{4'b0000, 4'b1000, 4'b0010, 4'b0011, 4'b0111, 4'b0110, 4'b0100};
        rstn = 1'b0; start = 1'b0; op = '0; a_in = '0; b_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_alu_bits", 32'({alu_a, alu_b, alu_cy_in}), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        do_op(4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0);
        do_op(4'b1000, 32'd5, 32'd7, 0, 0);
        do_op(4'b0111, 32'hF0F0_A5A5, 32'h0FF0_FF00, 0, 0);
        do_op(4'b0110, 32'hF0F0_A5A5, 32'h0FF0_FF00, 0, 0);
        do_op(4'b0100, 32'hF0F0_A5A5, 32'h0FF0_FF00, 0, 0);
        do_op(4'b0010, 32'h8000_0000, 32'h0000_0001, 0, 0);
        do_op(4'b0011, 32'h8000_0000, 32'h0000_0001, 0, 0);
        do_op(4'b0011, 32'd3, 32'd3, 0, 0);
        do_op(4'b0010, 32'hFFFF_FFFF, 32'd0, 0, 0);
        do_op(4'b0001, 32'h1234_5678, 32'h1111_1111, 0, 0);
`ifdef NANOV_ALU_SEQ_CHAIN_EN
        do_op(4'b0000, 32'd1, 32'd2, 5, 0);
`else
        do_op(4'b0000, 32'd1, 32'd2, 5, 33);
`endif

        // Asynchronous reset in the middle of a SUB
        @(negedge clk);
        start = 1'b1; op = 4'b1000; a_in = 32'd10; b_in = 32'd3;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_result", result, 32'd0);
        chk("mid_rst_alu_op", 32'(alu_op), 32'd0);
        chk("mid_rst_alu_bits", 32'({alu_a, alu_b, alu_cy_in}), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        quiet = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) quiet++;
        end
        chk("post_rst_quiet", 32'(quiet), 32'd0);
        do_op(4'b0000, 32'd2, 32'd2, 0, 0);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = (i % 5 == 0) ? ra : $urandom;
            if (i % 7 == 3) rb = ra ^ 32'h8000_0000;
            if (i % 6 == 1) ra = 32'($urandom_range(15));
            do_op(ops[$urandom_range(6)], ra, rb, 0, 0);
        end

`ifdef NANOV_ALU_SEQ_CHAIN_EN
        @(negedge clk);
        start = 1'b1; op = 4'b0000; a_in = 32'd1; b_in = 32'd1;
        d1 = 0; d2 = 0; drop = 0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done && d1 == 0) begin
                d1 = c;
                chk("chain_result1", result, 32'd2);
                start = 1'b1; op = 4'b1000; a_in = 32'd9; b_in = 32'd4;
            end else if (done && d2 == 0) begin
                d2 = c;
                chk("chain_result2", result, 32'd5);
            end
            if (d1 != 0 && d2 == 0 && !busy) drop++;
        end
        start = 1'b0;
        chk("chain_done1", 32'(d1), 32'd33);
        chk("chain_gap", 32'(d2 - d1), 32'd33);
        chk("chain_busy_drop", 32'(drop), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
